// File: rtl/adc_spi_if.sv
// rtl/adc_spi_if.sv - SPI pin bundle between the ADC reader and the serial converter
//
// Purpose: groups the three serial-ADC pins so the reader and the converter
//          model share one connection.
// Signals:
//   adc_sclk  serial clock, driven by the reader, idles high
//   adc_cs_n  chip select, driven by the reader, active low
//   adc_sdo   serial data, driven by the converter, changes after SCLK falls
// Modports:
//   master    reader side (drives adc_sclk/adc_cs_n, samples adc_sdo)
//   slave     converter side (samples adc_sclk/adc_cs_n, drives adc_sdo)

interface adc_spi_if;
  logic adc_sclk;
  logic adc_cs_n;
  logic adc_sdo;

  modport master (
    output adc_sclk,
    output adc_cs_n,
    input  adc_sdo
  );

  modport slave (
    input  adc_sclk,
    input  adc_cs_n,
    output adc_sdo
  );
endinterface

// File: rtl/adc_spi_reader.sv
// rtl/adc_spi_reader.sv - 10-bit serial ADC front end with parallel sample output
//
// Purpose: runs a 16-clock SPI conversion frame (3 leading zeros, 10 data bits
//          MSB first, 3 trailing zeros) back-to-back while enabled and presents
//          each good sample on adc_dout with a one-cycle strobe. Idle and reset
//          output is mid-scale (512) so downstream filters see zero current.
// Parameters:
//   SCLK_DIV  clk cycles per SCLK half-period (>= 1)
//   CS_SETUP  clk cycles from CS_n falling to the first SCLK falling edge (>= 1)
//   QUIET     clk cycles CS_n stays high between frames, DONE included (>= 2)
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      level, high = convert continuously
//   spi         ADC pins (master side)
//   adc_dout    last good sample, held between updates
//   dout_valid  one-cycle pulse when adc_dout updates
//   frame_err   one-cycle pulse when a frame has a non-zero header

module adc_spi_reader #(
  parameter int SCLK_DIV = 4,
  parameter int CS_SETUP = 2,
  parameter int QUIET    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  adc_spi_if.master  spi,
  output logic [9:0] adc_dout,
  output logic       dout_valid,
  output logic       frame_err
);

  // One shared counter times SETUP, each SCLK half-period and QUIET.
  localparam int MAX_A   = (SCLK_DIV > CS_SETUP) ? SCLK_DIV : CS_SETUP;
  localparam int MAX_CNT = (MAX_A > QUIET) ? MAX_A : QUIET;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  // DONE already accounts for one of the QUIET high cycles.
  localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET - 2);
  localparam logic [9:0]       MID_SCALE  = 10'd512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_QUIET
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [15:0]      shreg, shreg_n;
  logic             cs_n_q, cs_n_n;
  logic             sclk_q, sclk_n;
  logic [9:0]       dout_q, dout_n;
  logic             valid_q, valid_n;
  logic             err_q, err_n;

  assign spi.adc_cs_n = cs_n_q;
  assign spi.adc_sclk = sclk_q;
  assign adc_dout     = dout_q;
  assign dout_valid   = valid_q;
  assign frame_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      dout_q  <= MID_SCALE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      cs_n_q  <= cs_n_n;
      sclk_q  <= sclk_n;
      dout_q  <= dout_n;
      valid_q <= valid_n;
      err_q   <= err_n;
    end
  end

  // Next-state logic also computes the next value of every registered output,
  // so the pins change on the same edge as the state they belong to.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    cs_n_n    = cs_n_q;
    sclk_n    = sclk_q;
    dout_n    = dout_q;
    valid_n   = 1'b0;
    err_n     = 1'b0;

    case (state)
      S_IDLE: begin
        cs_n_n = 1'b1;
        sclk_n = 1'b1;
        if (enable) begin
          state_n = S_SETUP;
          cnt_n   = '0;
          cs_n_n  = 1'b0;
        end
      end

      S_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_n   = S_SHIFT;
          cnt_n     = '0;
          bit_cnt_n = '0;
          sclk_n    = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      // sclk_q doubles as the phase flag: low phase, then high phase.
      S_SHIFT: begin
        if (cnt != DIV_LAST) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = '0;
          if (!sclk_q) begin
            // Edge that raises SCLK: sample the bit the ADC set up on the fall.
            sclk_n  = 1'b1;
            shreg_n = {shreg[14:0], spi.adc_sdo};
          end else if (bit_cnt == 4'd15) begin
            state_n = S_DONE;
            cs_n_n  = 1'b1;
            if (shreg[15:13] == 3'b000) begin
              dout_n  = shreg[12:3];
              valid_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
            sclk_n    = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_n = S_QUIET;
        cnt_n   = '0;
      end

      S_QUIET: begin
        if (cnt == QUIET_LAST) begin
          cnt_n = '0;
          if (enable) begin
            state_n = S_SETUP;
            cs_n_n  = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        cs_n_n  = 1'b1;
        sclk_n  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb/tb_adc_spi_reader.sv - self-checking bench for adc_spi_reader (default and fast parameter sets)

module tb_adc_spi_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_n_b, enable, enable_b;
  logic [9:0] dout_a, dout_b;
  logic valid_a, valid_b, err_a, err_b;

  adc_spi_if spi_a();
  adc_spi_if spi_b();

  adc_spi_reader u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spi(spi_a),
    .adc_dout(dout_a), .dout_valid(valid_a), .frame_err(err_a)
  );

  adc_spi_reader #(.SCLK_DIV(1), .CS_SETUP(1), .QUIET(2)) u_b (
    .clk(clk), .rst_n(rst_n_b), .enable(enable_b), .spi(spi_b),
    .adc_dout(dout_b), .dout_valid(valid_b), .frame_err(err_b)
  );

  // Per-DUT views so one monitor and one ADC model serve both instances.
  logic       cs_w[2], sclk_w[2], val_w[2], err_w[2], rst_w[2];
  logic [9:0] dout_w[2];
  logic       sdo_r[2] = '{1'b0, 1'b0};

  assign cs_w[0] = spi_a.adc_cs_n;   assign cs_w[1] = spi_b.adc_cs_n;
  assign sclk_w[0] = spi_a.adc_sclk; assign sclk_w[1] = spi_b.adc_sclk;
  assign val_w[0] = valid_a;         assign val_w[1] = valid_b;
  assign err_w[0] = err_a;           assign err_w[1] = err_b;
  assign rst_w[0] = rst_n;           assign rst_w[1] = rst_n_b;
  assign dout_w[0] = dout_a;         assign dout_w[1] = dout_b;
  assign spi_a.adc_sdo = sdo_r[0];
  assign spi_b.adc_sdo = sdo_r[1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame words queued for the ADC model (written by the test, read by the model).
  logic [15:0] frames[2][64];
  int          wr[2] = '{0, 0};

  // ADC model and monitor state.
  int          rd[2] = '{0, 0};
  logic [15:0] cur[2] = '{16'h0, 16'h0};
  int          idx[2] = '{0, 0};
  int          rises[2] = '{0, 0};
  int          cs_falls[2] = '{0, 0};
  int          hi_run[2] = '{0, 0};
  int          gap_log[2][64];
  int          gap_n[2] = '{0, 0};
  int          both_high = 0;
  int          dout_jumps = 0;
  logic        prev_cs[2] = '{1'b1, 1'b1};
  logic        prev_sclk[2] = '{1'b1, 1'b1};
  logic        prev_rst[2] = '{1'b0, 1'b0};
  logic [9:0]  prev_dout[2] = '{10'd512, 10'd512};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (prev_cs[d] && !cs_w[d]) begin
        cur[d] = (rd[d] < wr[d]) ? frames[d][rd[d]] : 16'h0000;
        rd[d]++;
        idx[d] = 15;
        rises[d] = 0;
        cs_falls[d]++;
        if (gap_n[d] < 64) begin
          gap_log[d][gap_n[d]] = hi_run[d];
          gap_n[d]++;
        end
      end
      if (!cs_w[d] && prev_sclk[d] && !sclk_w[d] && idx[d] >= 0) begin
        sdo_r[d] = cur[d][idx[d]];
        idx[d]--;
      end
      if (!cs_w[d] && !prev_sclk[d] && sclk_w[d]) rises[d]++;
      if (val_w[d] && err_w[d]) both_high++;
      if (rst_w[d] && prev_rst[d] && !val_w[d] && dout_w[d] != prev_dout[d]) dout_jumps++;
      hi_run[d] = cs_w[d] ? hi_run[d] + 1 : 0;
      prev_cs[d] = cs_w[d];
      prev_sclk[d] = sclk_w[d];
      prev_rst[d] = rst_w[d];
      prev_dout[d] = dout_w[d];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [15:0] f);
    frames[d][wr[d]] = f;
    wr[d]++;
  endtask

  task automatic wait_strobe(input int d, input int max_cyc, output logic got,
                             output logic is_err, output int v, output int at);
    got = 1'b0; is_err = 1'b0; v = 0; at = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (val_w[d] || err_w[d]) begin
        got = 1'b1; is_err = err_w[d]; v = int'(dout_w[d]); at = cyc;
      end
    end
  endtask

  task automatic wait_rises(input int d, input int n, output logic ok);
    ok = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!cs_w[d] && rises[d] >= n) ok = 1'b1;
    end
  endtask

  // Reference: header must be zero, data is the 10 bits above the 3 trailing bits.
  function automatic void model(input logic [15:0] f, input int prev,
                                output int exp_err, output int exp_dout);
    int w;
    w = int'(f);
    if (w / 8192 == 0) begin
      exp_err = 0;
      exp_dout = (w / 8) % 1024;
    end else begin
      exp_err = 1;
      exp_dout = prev;
    end
  endfunction

  typedef struct {
    logic [15:0] frame;
    int          exp_err;
    int          exp_dout;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic got, is_err, ok;
    int v, at, start, prev_at, e_err, e_dout, ma, mb, g0, f0;
    logic [15:0] rf;

    tbl[0] = '{16'h0000, 0, 0};
    tbl[1] = '{16'h1FF8, 0, 1023};
    tbl[2] = '{16'h1000, 0, 512};
    tbl[3] = '{16'h15E0, 0, 700};
    tbl[4] = '{16'h12C0, 0, 600};
    tbl[5] = '{16'h4960, 1, 600};  // b14 set, data 300
    tbl[6] = '{16'h002F, 0, 5};    // trailing bits ignored
    tbl[7] = '{16'h8320, 1, 5};    // b15 set
    tbl[8] = '{16'h2048, 1, 5};    // b13 set

    // Reset with enable high.
    rst_n = 1'b0; rst_n_b = 1'b0; enable = 1'b1; enable_b = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_dout%0d", d), int'(dout_w[d]), 512);
      check($sformatf("reset_cs_n%0d", d), int'(cs_w[d]), 1);
      check($sformatf("reset_sclk%0d", d), int'(sclk_w[d]), 1);
      check($sformatf("reset_valid%0d", d), int'(val_w[d]), 0);
      check($sformatf("reset_err%0d", d), int'(err_w[d]), 0);
    end
    enable = 1'b0; enable_b = 1'b0;
    rst_n = 1'b1; rst_n_b = 1'b1;
    repeat (3) @(posedge clk);
    ma = 512; mb = 512;

    // Single conversion from a one-cycle enable pulse.
    push(0, 16'h1670);
    f0 = cs_falls[0];
    @(posedge clk); #1;
    enable = 1'b1; start = cyc;
    @(posedge clk); #1;
    enable = 1'b0;
    wait_strobe(0, 300, got, is_err, v, at);
    check("single_got", int'(got), 1);
    check("single_err", int'(is_err), 0);
    check("single_dout", v, 718);
    check("single_latency", at - start, 131);
    check("single_rises", rises[0], 16);
    ma = 718;
    repeat (300) @(negedge clk);
    check("single_cs_falls", cs_falls[0] - f0, 1);
    check("single_idle_cs", int'(cs_w[0]), 1);

    // Table-driven continuous run.
    for (int i = 0; i < 9; i++) push(0, tbl[i].frame);
    g0 = gap_n[0];
    @(posedge clk); #1;
    enable = 1'b1;
    prev_at = 0;
    for (int i = 0; i < 9; i++) begin
      wait_strobe(0, 400, got, is_err, v, at);
      if (i == 8) enable = 1'b0;
      check($sformatf("tbl%0d_got", i), int'(got), 1);
      check($sformatf("tbl%0d_err", i), int'(is_err), tbl[i].exp_err);
      check($sformatf("tbl%0d_dout", i), v, tbl[i].exp_dout);
      if (i > 0) check($sformatf("tbl%0d_period", i), at - prev_at, 134);
      prev_at = at;
    end
    ma = 5;
    for (int i = g0 + 1; i < gap_n[0]; i++)
      check($sformatf("tbl_gap%0d", i), gap_log[0][i], 4);
    repeat (20) @(negedge clk);

    // Randomized continuous run against the reference model.
    @(posedge clk); #1;
    enable = 1'b1;
    prev_at = 0;
    for (int i = 0; i < 12; i++) begin
      rf = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rf[15:13] = 3'b000;
      push(0, rf);
    end
    for (int i = 0; i < 12; i++) begin
      model(frames[0][wr[0] - 12 + i], ma, e_err, e_dout);
      wait_strobe(0, 400, got, is_err, v, at);
      if (i == 11) enable = 1'b0;
      check($sformatf("rnd%0d_got", i), int'(got), 1);
      check($sformatf("rnd%0d_err", i), int'(is_err), e_err);
      check($sformatf("rnd%0d_dout", i), v, e_dout);
      if (i > 0) check($sformatf("rnd%0d_period", i), at - prev_at, 134);
      prev_at = at;
      ma = e_dout;
    end
    repeat (20) @(negedge clk);

    // Enable dropped mid-frame: frame completes, then idle.
    push(0, 16'h0268);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_rises(0, 5, ok);
    enable = 1'b0;
    check("drop_reached", int'(ok), 1);
    wait_strobe(0, 300, got, is_err, v, at);
    check("drop_got", int'(got), 1);
    check("drop_err", int'(is_err), 0);
    check("drop_dout", v, 77);
    ma = 77;
    f0 = cs_falls[0];
    wait_strobe(0, 300, got, is_err, v, at);
    check("drop_no_more_strobe", int'(got), 0);
    check("drop_no_more_cs", cs_falls[0] - f0, 0);
    check("drop_idle_cs", int'(cs_w[0]), 1);

    // Reset asserted mid-frame.
    push(0, 16'h03D8);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_rises(0, 8, ok);
    check("rst_reached", int'(ok), 1);
    rst_n = 1'b0;
    #1;
    check("rst_cs_n", int'(cs_w[0]), 1);
    check("rst_sclk", int'(sclk_w[0]), 1);
    check("rst_dout", int'(dout_w[0]), 512);
    check("rst_valid", int'(val_w[0]), 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_strobe(0, 300, got, is_err, v, at);
    check("rst_no_partial", int'(got), 0);
    ma = 512;

    // Fast parameter set on the second instance.
    for (int i = 0; i < 8; i++) begin
      rf = 16'($urandom);
      if ($urandom_range(0, 3) != 0) rf[15:13] = 3'b000;
      push(1, rf);
    end
    g0 = gap_n[1];
    @(posedge clk); #1;
    enable_b = 1'b1;
    prev_at = 0;
    for (int i = 0; i < 8; i++) begin
      model(frames[1][i], mb, e_err, e_dout);
      wait_strobe(1, 100, got, is_err, v, at);
      if (i == 7) enable_b = 1'b0;
      check($sformatf("fast%0d_got", i), int'(got), 1);
      check($sformatf("fast%0d_err", i), int'(is_err), e_err);
      check($sformatf("fast%0d_dout", i), v, e_dout);
      if (i > 0) check($sformatf("fast%0d_period", i), at - prev_at, 35);
      prev_at = at;
      mb = e_dout;
    end
    for (int i = g0 + 1; i < gap_n[1]; i++)
      check($sformatf("fast_gap%0d", i), gap_log[1][i], 2);
    repeat (20) @(negedge clk);

    check("strobes_never_together", both_high, 0);
    check("dout_only_changes_with_valid", dout_jumps, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_spi_reader.md
# adc_spi_reader

Serial-ADC front end that runs a 10-bit SPI converter (16-clock frame: 3 leading zeros, 10 data bits MSB first, 3 trailing zeros) and presents each conversion as a parallel `adc_dout` word with a one-cycle valid strobe. It sits between the board's current-sense ADC pins and the QCW over-current detector, which consumes `adc_dout`. Conversions repeat back-to-back while `enable` is high. Reset and idle output is mid-scale (512), so a downstream filter sees zero current.

## Interface
- `SCLK_DIV`, 4: clk cycles per SCLK half-period (≥1).
- `CS_SETUP`, 2: clk cycles from CS_n falling to first SCLK falling edge (≥1).
- `QUIET`, 4: clk cycles CS_n stays high between frames, DONE cycle included (≥2).
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; high = run conversions continuously.
- `adc_sdo`  in  1  ADC serial data; changes after SCLK falling edges.
- `adc_sclk`  out  1  serial clock; idles high.
- `adc_cs_n`  out  1  chip select, active low.
- `adc_dout`  out  10  last good sample; held between updates.
- `dout_valid`  out  1  one-cycle pulse when `adc_dout` updates.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- States: IDLE, SETUP, SHIFT, DONE, QUIET.
- IDLE: `adc_cs_n`=1, `adc_sclk`=1. If `enable`=1, go to SETUP next cycle.
- SETUP: `adc_cs_n`=0, `adc_sclk`=1 for `CS_SETUP` cycles, then SHIFT.
- SHIFT: 16 SCLK periods. Each period is low for `SCLK_DIV` cycles, then high for `SCLK_DIV` cycles.
- `adc_sdo` is captured into a 16-bit shift register, MSB first, on the clk edge that drives `adc_sclk` low→high.
- After the 16th high phase, go to DONE.
- DONE (1 cycle): `adc_cs_n`=1, `adc_sclk`=1. Frame bits b15..b0 are checked:
  - b15..b13 all zero: `adc_dout` ← b12..b3 and `dout_valid`=1.
  - otherwise: `adc_dout` is held and `frame_err`=1.
  - Trailing bits b2..b0 are ignored.
- QUIET: `adc_cs_n`=1 for the remaining `QUIET`−1 cycles. Then go to SETUP if `enable`=1, else IDLE.
- `enable` is sampled only in IDLE and at the end of QUIET. Deasserting it mid-frame does not abort the frame; the frame completes and is reported normally.
- `dout_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset (async assert, sync release):
  - state IDLE, `adc_cs_n`=1, `adc_sclk`=1
  - `adc_dout`=10'd512, `dout_valid`=0, `frame_err`=0
  - shift register and counters cleared
- Reset mid-frame: CS_n rises immediately and no partial sample is reported.
- All outputs are registered; no combinational path from inputs to outputs.
- `enable` rising in IDLE → `adc_cs_n` falls on the next clk edge.
- Frame period with `enable` held high: `CS_SETUP` + 32·`SCLK_DIV` + `QUIET` cycles (defaults: 134).
- `adc_dout` and `dout_valid` change on the same edge. `adc_dout` is stable for the whole frame period that follows.
- First SCLK falling edge comes exactly `CS_SETUP` cycles after CS_n falls.
- Last SCLK rising edge comes `SCLK_DIV` cycles before CS_n rises.
- `SCLK_DIV`=1: SCLK toggles every cycle; the capture rule is unchanged.

## Test plan
- Reset check: hold `rst_n`=0 with `enable`=1 → `adc_dout`=512, `adc_cs_n`=1, `adc_sclk`=1, both strobes 0.
- Single conversion: ADC model returns 16'b000_1011001110_000; pulse `enable` for 1 cycle →
  - exactly 16 SCLK rising edges
  - `adc_dout`=0x2CE and one `dout_valid`, 1 + 2 + 128 = 131 cycles after the `enable` edge
  - then back to IDLE
- Continuous run: `enable`=1 with model values 0, 1023, 512, 700 → matching `adc_dout` sequence, `dout_valid` exactly 134 cycles apart, CS_n high for 4 cycles between frames.
- Framing error: model drives b14=1 with data 300 after a good 600 → `frame_err` pulses once, no `dout_valid`, `adc_dout` stays 600.
- Mid-frame control:
  - drop `enable` after the 5th SCLK rise → frame completes, `dout_valid` fires, then IDLE with no further CS_n activity.
  - assert `rst_n`=0 after the 8th SCLK rise → `adc_cs_n`=1 and `adc_dout`=512 within the same cycle.
- Parameter sweep `SCLK_DIV`=1, `CS_SETUP`=1, `QUIET`=2 → period = 1 + 32 + 2 = 35 cycles; values match the model.
